// File: rtl/rs232_rx.sv
// rtl/rs232_rx.sv - UART/RS232 serial receiver with oversampled bit timing
//
// Deserialises an asynchronous rx line into parallel words. Frame format:
// 1 start bit, DATA_BITS data bits LSB first, optional parity bit, 1 stop bit.
//
// Ports:
//   clk        system clock
//   rst        asynchronous, active-high reset
//   clk_os_en  oversample strobe, one clk wide, at OS_RATE x baud
//   rx         serial line, asynchronous to clk, idle high
//   rx_data    last good received word, held until the next good frame
//   rx_valid   1-clk pulse, rx_data updated
//   frame_err  1-clk pulse, stop bit sampled 0
//   parity_err 1-clk pulse, parity mismatch
//   busy       high whenever the receiver is not idle

module rs232_rx #(
   parameter int DATA_BITS  = 8,
   parameter int OS_RATE    = 16,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clk_os_en,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 frame_err,
   output logic                 parity_err,
   output logic                 busy
);

   localparam int OS_W  = $clog2(OS_RATE);
   localparam int BIT_W = $clog2(DATA_BITS + 1);

   localparam logic [OS_W-1:0]  OS_HALF  = OS_W'(OS_RATE / 2 - 1);
   localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OS_RATE - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);
   localparam logic             HAS_PAR  = (PARITY_EN != 0);
   localparam logic             ODD      = (PARITY_ODD != 0);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] START  = 3'd1;
   localparam logic [2:0] DATA   = 3'd2;
   localparam logic [2:0] PARITY = 3'd3;
   localparam logic [2:0] STOP   = 3'd4;

   logic [2:0]           state;
   logic                 sync1;
   logic                 rxs;
   logic [OS_W-1:0]      os_cnt;
   logic [BIT_W-1:0]     bit_cnt;
   logic [DATA_BITS-1:0] shreg;
   logic                 par_bad;

   assign busy = (state != IDLE);

   // Two-flop synchroniser; resets to the idle (high) line level so that
   // reset release never looks like a start edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= 1'b1;
         rxs   <= 1'b1;
      end else begin
         sync1 <= rx;
         rxs   <= sync1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         os_cnt     <= '0;
         bit_cnt    <= '0;
         shreg      <= '0;
         par_bad    <= 1'b0;
         rx_data    <= '0;
         rx_valid   <= 1'b0;
         frame_err  <= 1'b0;
         parity_err <= 1'b0;
      end else begin
         // Pulses are cleared every clk, not every tick, so each is exactly
         // one clk wide.
         rx_valid   <= 1'b0;
         frame_err  <= 1'b0;
         parity_err <= 1'b0;

         if (clk_os_en) begin
            case (state)
               IDLE: begin
                  if (!rxs) begin
                     state  <= START;
                     os_cnt <= '0;
                  end
               end

               START: begin
                  if (os_cnt == OS_HALF) begin
                     if (rxs) begin
                        state <= IDLE;
                     end else begin
                        state   <= DATA;
                        os_cnt  <= '0;
                        bit_cnt <= '0;
                        par_bad <= 1'b0;
                     end
                  end else begin
                     os_cnt <= os_cnt + 1'b1;
                  end
               end

               // From here on, samples land one full bit after the mid-start
               // sample, i.e. in the middle of each following bit.
               DATA: begin
                  os_cnt <= os_cnt + 1'b1;
                  if (os_cnt == OS_LAST) begin
                     shreg   <= {rxs, shreg[DATA_BITS-1:1]};
                     bit_cnt <= bit_cnt + 1'b1;
                     if (bit_cnt == BIT_LAST)
                        state <= HAS_PAR ? PARITY : STOP;
                  end
               end

               PARITY: begin
                  os_cnt <= os_cnt + 1'b1;
                  if (os_cnt == OS_LAST) begin
                     par_bad <= ((^shreg) ^ rxs) != ODD;
                     state   <= STOP;
                  end
               end

               STOP: begin
                  os_cnt <= os_cnt + 1'b1;
                  if (os_cnt == OS_LAST) begin
                     state <= IDLE;
                     if (!rxs)
                        frame_err <= 1'b1;
                     if (par_bad)
                        parity_err <= 1'b1;
                     if (rxs && !par_bad) begin
                        rx_data  <= shreg;
                        rx_valid <= 1'b1;
                     end
                  end
               end

               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
